mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares one single-ported unified memory between the ARM core's instruction-fetch port and its data port. It serialises fetch and load/store requests through a req/ack handshake and drives the memory with a fixed read latency. It sits between `arm` and the memory model in the top level and replaces the separate instruction and data memories with one shared array.

## Interface
Parameters:
- `AW`, 32, address width (passed through unchanged, no alignment checks)
- `DW`, 32, data width
- `MEM_LAT`, 1, memory read latency in cycles; legal range 1..8

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset; asserted when 0
- `i_req`  in  1  fetch request; held with `i_addr` stable until `i_ack`
- `i_addr`  in  AW  fetch address
- `i_ack`  out  1  one-cycle fetch completion pulse; `i_rdata` valid in the same cycle
- `i_rdata`  out  DW  fetched instruction, registered
- `d_req`  in  1  data request; held with `d_we`, `d_addr` and `d_wdata` stable until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_ack`  out  1  one-cycle data completion pulse; for loads, `d_rdata` is valid in the same cycle
- `d_rdata`  out  DW  load data, registered
- `mem_en`  out  1  memory access strobe, asserted for one cycle per access
- `mem_we`  out  1  memory write enable; qualified by `mem_en`
- `mem_addr`  out  AW  memory address, registered at grant
- `mem_wdata`  out  DW  memory write data, registered at grant
- `mem_rdata`  in  DW  memory read data, valid `MEM_LAT` cycles after the `mem_en` cycle

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If neither request is pending, stay in IDLE.
  - Otherwise grant one requester, latch its address, write data and write enable into the `mem_*` registers, record the owner, then go to ISSUE.
- **ISSUE:**
  - `mem_en` = 1 and `mem_we` = the owner's write enable (0 for fetch).
  - A store goes next to RESP.
  - A read (fetch or load) loads the latency counter with `MEM_LAT` and goes to WAIT.
- **WAIT:**
  - The counter decrements every cycle.
  - When the counter reaches 1, capture `mem_rdata` into the owner's rdata register and go to RESP.
- **RESP:**
  - The owner's ack = 1 for exactly one cycle, then return to IDLE.
  - Requests are not sampled in RESP, so a req still high in the ack cycle is not re-granted.
- Only the owner's rdata register updates. The non-owner's rdata holds its last value.
- `mem_addr`, `mem_wdata` and `mem_we` hold their values outside ISSUE; only `mem_en` qualifies an access.
- Arbitration on simultaneous requests in IDLE is set by `ARB_ROUND_ROBIN_EN` (see Configuration).
- A single pending request is always granted immediately, regardless of arbitration mode.
- A req dropped before its ack is a protocol violation; the arbiter completes the access anyway.
- **Reset** (`reset` = 0 at a rising edge):
  - FSM returns to IDLE and any in-flight access is dropped with no ack.
  - `i_ack`, `d_ack`, `mem_en` and `mem_we` go to 0.
  - `i_rdata`, `d_rdata`, `mem_addr` and `mem_wdata` go to 0.
  - The last-grant register resets to "fetch".

## Timing
- Request sampled at edge E0 (cycle 0 in IDLE); ISSUE is cycle 1.
- Read (fetch or load): `mem_rdata` valid in cycle 1+`MEM_LAT`; ack in cycle 2+`MEM_LAT`.
- Store: memory write occurs at the end of cycle 1; ack in cycle 2.
- Throughput:
  - A back-to-back read occupies `MEM_LAT`+3 cycles, because IDLE is always visited between accesses.
  - A back-to-back store occupies 3 cycles.
- All outputs are registered; there are no combinational paths from the request inputs to the outputs.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous `i_req` and `d_req` in IDLE, grant the port not granted last.
  - Last-grant updates on every grant and resets to fetch, so the first tie goes to data.
- Undefined:
  - Fixed priority; data always wins a tie and fetch can be starved.
  - The last-grant register is not implemented.

## Test plan
- `MEM_LAT`=1, memory word 0x100 = 0xE3A00005; `i_req` with `i_addr`=0x100 at E0 -> `mem_en` in cycle 1, `i_ack`=1 and `i_rdata`=0xE3A00005 in cycle 3, `d_ack` stays 0.
- Store `d_addr`=0x200, `d_wdata`=0xDEADBEEF, then load 0x200 -> `mem_we`=1 in ISSUE; `d_ack` 2 cycles after the store is sampled; the load returns 0xDEADBEEF.
- `MEM_LAT`=3: load issued -> `d_ack` exactly 5 cycles after sampling; `i_rdata` unchanged throughout.
- Both reqs held continuously, round-robin build -> grants alternate D,I,D,I; fixed-priority build -> D only and `i_ack` never asserts.
- `reset` driven to 0 in WAIT of a fetch -> next cycle all outputs 0 and no `i_ack`; the re-issued fetch completes normally.
- req held high through its ack cycle -> no duplicate grant; the second access is issued only after passing through IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter sharing one single-ported memory between fetch and data ports.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: data wins).
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e     state_q;
    logic       owner_d_q;
    logic [3:0] lat_q;
    logic       grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;

    // On a tie, hand the memory to whichever port did not get the previous grant.
    always_comb begin
        grant_d = d_req && (!i_req || !last_d_q);
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            owner_d_q <= 1'b0;
            lat_q     <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q  <= 1'b0;
`endif
        end else begin
            i_ack  <= 1'b0;
            d_ack  <= 1'b0;
            mem_en <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_req || d_req) begin
                        owner_d_q <= grant_d;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_d && d_we;
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        if (grant_d) begin
                            mem_wdata <= d_wdata;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_q  <= grant_d;
`endif
                        state_q   <= StIssue;
                    end
                end
                StIssue: begin
                    // Only a data grant can set mem_we, so a store always belongs to the data port.
                    if (mem_we) begin
                        d_ack   <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        lat_q   <= 4'(MEM_LAT);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (lat_q == 4'd1) begin
                        if (owner_d_q) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end
                        state_q <= StResp;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed steps plus randomized traffic against a
// transaction-level model; a second instance with MEM_LAT=3 checks the longer latency.
module tb_mem_arbiter;

    localparam int unsigned LAT  = 1;
    localparam int unsigned LAT3 = 3;
    localparam logic [31:0] BAD  = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, mem_en, mem_we;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        reset3, i_req3, d_req3, d_we3;
    logic [31:0] i_addr3, d_addr3, d_wdata3;
    logic        i_ack3, d_ack3, mem_en3, mem_we3;
    logic [31:0] i_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT3)) u_dut3 (
        .clk(clk), .reset(reset3),
        .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_ack(d_ack3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 64) ? 32'hE3A0_0005 : (32'h5A5A_0000 + 32'(i));
    endfunction

    // Memory model for the LAT=1 instance: read data valid only in the cycle after mem_en.
    bit   [255:0] env_wr;
    logic [31:0]  env_mem [256];
    logic [31:0]  rd_pipe;
    always @(posedge clk) begin
        rd_pipe <= BAD;
        if (mem_en === 1'b1) begin
            if (mem_we) begin
                env_mem[mem_addr[9:2]] <= mem_wdata;
                env_wr[mem_addr[9:2]]  <= 1'b1;
            end else begin
                rd_pipe <= env_wr[mem_addr[9:2]] ? env_mem[mem_addr[9:2]]
                                                 : init_word(int'(mem_addr[9:2]));
            end
        end
    end
    assign mem_rdata = rd_pipe;

    // Read-only memory for the LAT=3 instance: data valid exactly 3 cycles after mem_en.
    logic [31:0] p3_0, p3_1, p3_2;
    always @(posedge clk) begin
        p3_0 <= (mem_en3 === 1'b1 && !mem_we3) ? init_word(int'(mem_addr3[9:2])) : BAD;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign mem_rdata3 = p3_2;

    // Transaction-level reference state.
    int          tests = 0, fails = 0;
    int          cyc = 0, issue_cyc = -10, ack_cyc = -10;
    bit          own_d, own_we, last_d, wd_known;
    logic [31:0] own_rd, exp_i_rdata, exp_d_rdata, exp_mem_addr, exp_mem_wdata;
    logic        exp_mem_we;
    logic [31:0] ref_mem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Apply the inputs of the current cycle to the model (they are sampled at the next edge).
    task automatic commit();
        bit gd;
        int idx;
        if (!reset) begin
            issue_cyc     = -10;
            ack_cyc       = -10;
            last_d        = 1'b0;
            exp_i_rdata   = '0;
            exp_d_rdata   = '0;
            exp_mem_addr  = '0;
            exp_mem_we    = 1'b0;
            exp_mem_wdata = '0;
            wd_known      = 1'b1;
        end else if (cyc > ack_cyc && (i_req || d_req)) begin
            if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                gd = !last_d;
`else
                gd = 1'b1;
`endif
            end else begin
                gd = d_req;
            end
            own_d        = gd;
            own_we       = gd && d_we;
            last_d       = gd;
            exp_mem_addr = gd ? d_addr : i_addr;
            exp_mem_we   = own_we;
            idx          = int'(exp_mem_addr[9:2]);
            if (own_we) begin
                exp_mem_wdata = d_wdata;
                wd_known      = 1'b1;
                ref_mem[idx]  = d_wdata;
            end else begin
                wd_known = 1'b0;
                own_rd   = ref_mem[idx];
            end
            issue_cyc = cyc + 1;
            ack_cyc   = own_we ? cyc + 2 : cyc + 2 + int'(LAT);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == ack_cyc && !own_we) begin
            if (own_d) exp_d_rdata = own_rd;
            else       exp_i_rdata = own_rd;
        end
        chk("i_ack", 32'(i_ack), 32'(cyc == ack_cyc && !own_d));
        chk("d_ack", 32'(d_ack), 32'(cyc == ack_cyc && own_d));
        chk("mem_en", 32'(mem_en), 32'(cyc == issue_cyc));
        chk("mem_we", 32'(mem_we), 32'(exp_mem_we));
        chk("mem_addr", mem_addr, exp_mem_addr);
        chk("i_rdata", i_rdata, exp_i_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        if (wd_known) chk("mem_wdata", mem_wdata, exp_mem_wdata);
    endtask

    task automatic step();
        commit();
        tick();
    endtask

    task automatic wait_ack();
        step();
        for (int n = 0; n < 16 && cyc != ack_cyc; n++) step();
    endtask

    task automatic new_i();
        i_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    endtask

    task automatic new_d();
        d_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        reset3 = 1'b0; i_req3 = 1'b0; d_req3 = 1'b0; d_we3 = 1'b0;
        i_addr3 = '0; d_addr3 = '0; d_wdata3 = '0;

        step();
        step();
        reset = 1'b1;

        // Single fetch of 0x100.
        i_req = 1'b1; i_addr = 32'h100;
        wait_ack();
        i_req = 1'b0;
        step();

        // Store then load at 0x200.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        wait_ack();
        d_req = 1'b0;
        step();
        d_req = 1'b1; d_we = 1'b0;
        wait_ack();
        d_req = 1'b0;
        step();

        // Reset while a fetch is in WAIT; the held fetch is re-issued afterwards.
        i_req = 1'b1; i_addr = 32'h104;
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        wait_ack();
        i_req = 1'b0;
        step();

        // Request held through its ack cycle must not be re-granted in RESP.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h208;
        wait_ack();
        step();
        d_req = 1'b0;
        step();
        step();

        // Both ports requesting continuously.
        i_req = 1'b1; i_addr = 32'h10C;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h110;
        repeat (4) wait_ack();
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            if (i_req && cyc == ack_cyc && !own_d) begin
                if ($urandom_range(0, 1) == 0) i_req = 1'b0;
                else new_i();
            end else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1;
                new_i();
            end
            if (d_req && cyc == ack_cyc && own_d) begin
                if ($urandom_range(0, 1) == 0) d_req = 1'b0;
                else new_d();
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1;
                new_d();
            end
            reset = ($urandom_range(0, 79) != 0);
            step();
        end
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
        repeat (8) step();

        // MEM_LAT=3 instance: load acked exactly 5 cycles after being sampled.
        reset3 = 1'b1;
        step();
        d_req3 = 1'b1; d_addr3 = 32'h200;
        for (int n = 1; n <= 7; n++) begin
            step();
            chk("lat3_d_ack", 32'(d_ack3), 32'(n == 5));
            chk("lat3_mem_en", 32'(mem_en3), 32'(n == 1));
            chk("lat3_i_rdata", i_rdata3, 32'h0);
            chk("lat3_i_ack", 32'(i_ack3), 32'h0);
            if (n == 5) begin
                chk("lat3_d_rdata", d_rdata3, init_word(128));
                d_req3 = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
